// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-RAM arbiter: FSM state, response
// owner tag and the byte-address legality check.
package dmem_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_t;

  localparam int unsigned BUS_ADDR_W = 32;

  // Word-aligned and inside a RAM of `depth` words (depth is a power of two).
  function automatic logic addr_ok(input logic [BUS_ADDR_W-1:0] addr,
                                   input int unsigned          depth);
    logic [BUS_ADDR_W+1:0] limit;
    limit = {depth[BUS_ADDR_W-1:0], 2'b00};
    return (addr[1:0] == 2'b00) && ({2'b00, addr} < limit);
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr.sv
// Two-way round-robin core: index 0 is the CPU, index 1 the debug port.
// The pointer favours the requester that lost the most recent grant.
module rr_arb2 #(
  parameter int CPU_FIRST = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       update_i,
  input  logic       mask_cpu_i,
  output logic [1:0] gnt_o,
  output logic       ptr_o
);

  logic [1:0] req_s;
  logic       ptr_q;
  logic       ptr_d;

  // ptr_q = 0 favours the CPU, 1 favours DBG
  always_comb begin
    req_s = {req_i[1], req_i[0] & ~mask_cpu_i};
    gnt_o = 2'b00;
    case (req_s)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    if (update_i) begin
      ptr_d = gnt_o[0];
    end else begin
      ptr_d = ptr_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= (CPU_FIRST != 0) ? 1'b0 : 1'b1;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data RAM arbiter between the CPU load/store port and the
// debug/loader port: round-robin with debug lock, range check, 1-cycle reads.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024,
  parameter int ADDR_BITS  = $clog2(MEM_DEPTH),
  parameter int CPU_FIRST  = 1
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [31:0]           cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_err,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [31:0]           dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  dbg_err,
  input  logic                  dbg_lock,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_BITS-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  arb_state_t            state_q;
  owner_t                own_q;
  owner_t                own_d;
  logic                  rsp_v_q;
  logic                  rsp_v_d;
  logic                  rsp_err_q;
  logic                  rsp_err_d;
  logic [DATA_WIDTH-1:0] cpu_rdata_q;
  logic [DATA_WIDTH-1:0] cpu_rdata_d;
  logic [DATA_WIDTH-1:0] dbg_rdata_q;
  logic [DATA_WIDTH-1:0] dbg_rdata_d;

  logic [1:0]            req_s;
  logic [1:0]            arb_gnt_s;
  logic [1:0]            gnt_s;
  logic                  mask_cpu_s;
  logic                  upd_s;
  logic                  ptr_unused_s;
  logic                  sel_we_s;
  logic                  sel_ok_s;
  logic [31:0]           sel_addr_s;
  logic [DATA_WIDTH-1:0] sel_wdata_s;
  logic                  cpu_live_s;
  logic                  dbg_live_s;

  // In LOCK the CPU is masked only while the lock is still held; the cycle
  // the lock drops is arbitrated normally, and the pointer already favours
  // the CPU because every grant inside LOCK went to DBG.
  assign req_s      = {dbg_req, cpu_req};
  assign mask_cpu_s = (state_q == LOCK) && dbg_lock;
  assign gnt_s      = arb_gnt_s & {2{~RESET_N}};
  assign upd_s      = |gnt_s;

  rr_arb2 #(
    .CPU_FIRST (CPU_FIRST)
  ) u_rr (
    .clk_i      (CLK),
    .rst_i      (RESET_N),
    .req_i      (req_s),
    .update_i   (upd_s),
    .mask_cpu_i (mask_cpu_s),
    .gnt_o      (arb_gnt_s),
    .ptr_o      (ptr_unused_s)
  );

  assign cpu_gnt = gnt_s[0];
  assign dbg_gnt = gnt_s[1];

  // Steer the winning request onto the RAM side
  always_comb begin
    if (gnt_s[1]) begin
      sel_we_s    = dbg_we;
      sel_addr_s  = dbg_addr;
      sel_wdata_s = dbg_wdata;
    end else begin
      sel_we_s    = cpu_we;
      sel_addr_s  = cpu_addr;
      sel_wdata_s = cpu_wdata;
    end
    sel_ok_s = addr_ok(sel_addr_s, MEM_DEPTH);
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if ((|gnt_s) && sel_ok_s) begin
      mem_en    = 1'b1;
      mem_we    = sel_we_s;
      mem_addr  = sel_addr_s[ADDR_BITS+1:2];
      mem_wdata = sel_wdata_s;
    end else begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
    end
  end

  // Reads and rejected accesses owe a response next cycle; legal writes do not
  always_comb begin
    own_d     = own_q;
    rsp_v_d   = 1'b0;
    rsp_err_d = 1'b0;
    if (|gnt_s) begin
      own_d     = gnt_s[1] ? OWN_DBG : OWN_CPU;
      rsp_v_d   = !sel_ok_s || !sel_we_s;
      rsp_err_d = !sel_ok_s;
    end else begin
      rsp_v_d   = 1'b0;
      rsp_err_d = 1'b0;
    end
  end

  assign cpu_live_s = rsp_v_q && !rsp_err_q && (own_q == OWN_CPU);
  assign dbg_live_s = rsp_v_q && !rsp_err_q && (own_q == OWN_DBG);

  // Read data is passed straight from the RAM in the response cycle and then
  // held; a rejected access preloads zero so its response reads as 0.
  always_comb begin
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    if (gnt_s[0] && !sel_ok_s) begin
      cpu_rdata_d = '0;
    end else if (cpu_live_s) begin
      cpu_rdata_d = mem_rdata;
    end else begin
      cpu_rdata_d = cpu_rdata_q;
    end
    if (gnt_s[1] && !sel_ok_s) begin
      dbg_rdata_d = '0;
    end else if (dbg_live_s) begin
      dbg_rdata_d = mem_rdata;
    end else begin
      dbg_rdata_d = dbg_rdata_q;
    end
  end

  always_ff @(posedge CLK or posedge RESET_N) begin
    if (RESET_N) begin
      state_q <= ARB;
    end else begin
      case (state_q)
        ARB: begin
          if (gnt_s[1] && dbg_lock) begin
            state_q <= LOCK;
          end else begin
            state_q <= ARB;
          end
        end
        LOCK: begin
          if (!dbg_lock) begin
            state_q <= ARB;
          end else begin
            state_q <= LOCK;
          end
        end
        default: state_q <= ARB;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET_N) begin
    if (RESET_N) begin
      own_q       <= OWN_CPU;
      rsp_v_q     <= 1'b0;
      rsp_err_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      own_q       <= own_d;
      rsp_v_q     <= rsp_v_d;
      rsp_err_q   <= rsp_err_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  assign cpu_rvalid = rsp_v_q && (own_q == OWN_CPU);
  assign cpu_err    = rsp_v_q && rsp_err_q && (own_q == OWN_CPU);
  assign cpu_rdata  = cpu_live_s ? mem_rdata : cpu_rdata_q;
  assign dbg_rvalid = rsp_v_q && (own_q == OWN_DBG);
  assign dbg_err    = rsp_v_q && rsp_err_q && (own_q == OWN_DBG);
  assign dbg_rdata  = dbg_live_s ? mem_rdata : dbg_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised bench for dmem_arbiter against a transaction-level reference
// model (favoured-port flag, lock flag, shadow RAM, per-port pending reply).
module tb_dmem_arbiter;

  localparam int DW        = 32;
  localparam int DEPTH     = 1024;
  localparam int AB        = $clog2(DEPTH);
  localparam int CPU_FIRST = 1;

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b1;
  logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid, cpu_err;
  logic [31:0]   cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dbg_req, dbg_we, dbg_gnt, dbg_rvalid, dbg_err, dbg_lock;
  logic [31:0]   dbg_addr;
  logic [DW-1:0] dbg_wdata, dbg_rdata;
  logic          mem_en, mem_we;
  logic [AB-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  always #5 CLK = ~CLK;

  dmem_arbiter #(
    .DATA_WIDTH (DW),
    .MEM_DEPTH  (DEPTH),
    .CPU_FIRST  (CPU_FIRST)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
    .dbg_lock(dbg_lock),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] seed_word(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'hA5A5_0F0F;
  endfunction

  // Environment RAM: unwritten words read back as seed_word(index)
  logic [DW-1:0] ram    [DEPTH];
  bit            ram_wr [DEPTH];
  always @(posedge CLK) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr]    <= mem_wdata;
        ram_wr[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= ram_wr[mem_addr] ? ram[mem_addr] : seed_word(int'(mem_addr));
      end
    end
  end

  int            n_checks = 0;
  int            n_pass   = 0;
  string         pn [2] = '{"cpu", "dbg"};

  // Reference model state
  int            fav;
  bit            locked;
  bit            pv [2];
  bit            perr [2];
  logic [31:0]   pdata [2];
  logic [31:0]   last_rd [2];
  bit            granted [2];
  logic [31:0]   shadow [DEPTH];

  // Drive values and per-cycle observations for directed checks
  logic          d_req [2];
  logic          d_we [2];
  logic [31:0]   d_addr [2];
  logic [31:0]   d_wd [2];
  logic          d_lock;
  logic          obs_cpu_gnt, obs_mem_en, obs_cpu_rvalid, obs_cpu_err;
  logic [AB-1:0] obs_mem_addr;
  logic [31:0]   obs_cpu_rdata;
  int            tp_gnt, tp_rv;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    fav    = (CPU_FIRST != 0) ? 0 : 1;
    locked = 1'b0;
    for (int p = 0; p < 2; p++) begin
      pv[p] = 1'b0; perr[p] = 1'b0; pdata[p] = 32'd0; last_rd[p] = 32'd0; granted[p] = 1'b0;
    end
  endtask

  task automatic model_cycle();
    logic        rq [2], wa [2], rv [2], er [2];
    logic [31:0] ad [2], wd [2], rd [2];
    int          win;
    bit          ce, legal;
    longint unsigned av;
    rq[0] = cpu_req;    rq[1] = dbg_req;
    wa[0] = cpu_we;     wa[1] = dbg_we;
    ad[0] = cpu_addr;   ad[1] = dbg_addr;
    wd[0] = cpu_wdata;  wd[1] = dbg_wdata;
    rv[0] = cpu_rvalid; rv[1] = dbg_rvalid;
    er[0] = cpu_err;    er[1] = dbg_err;
    rd[0] = cpu_rdata;  rd[1] = dbg_rdata;
    for (int p = 0; p < 2; p++) begin
      if (pv[p]) last_rd[p] = perr[p] ? 32'd0 : pdata[p];
      check_val({pn[p], "_rvalid"}, 64'(rv[p]), 64'(pv[p]));
      check_val({pn[p], "_err"}, 64'(er[p]), 64'(pv[p] & perr[p]));
      check_val({pn[p], "_rdata"}, 64'(rd[p]), 64'(last_rd[p]));
      pv[p] = 1'b0; perr[p] = 1'b0; granted[p] = 1'b0;
    end
    ce = rq[0] && !(locked && dbg_lock);
    if (ce && rq[1]) win = fav;
    else if (ce) win = 0;
    else if (rq[1]) win = 1;
    else win = -1;
    check_val("cpu_gnt", 64'(cpu_gnt), 64'(win == 0));
    check_val("dbg_gnt", 64'(dbg_gnt), 64'(win == 1));
    if (win < 0) begin
      check_val("idle_mem_en", 64'(mem_en), 64'd0);
    end else begin
      granted[win] = 1'b1;
      av    = 64'(ad[win]);
      legal = (av % 4 == 0) && (av < 64'(DEPTH) * 4);
      check_val("mem_en", 64'(mem_en), 64'(legal));
      if (!legal) begin
        pv[win] = 1'b1; perr[win] = 1'b1;
      end else begin
        check_val("mem_we", 64'(mem_we), 64'(wa[win]));
        check_val("mem_addr", 64'(mem_addr), av / 4);
        if (wa[win]) begin
          check_val("mem_wdata", 64'(mem_wdata), 64'(wd[win]));
          shadow[int'(av / 4)] = wd[win];
        end else begin
          pv[win] = 1'b1; pdata[win] = shadow[int'(av / 4)];
        end
      end
      fav = 1 - win;
    end
    if (!dbg_lock) locked = 1'b0;
    else if (win == 1) locked = 1'b1;
  endtask

  task automatic step();
    cpu_req = d_req[0]; cpu_we = d_we[0]; cpu_addr = d_addr[0]; cpu_wdata = d_wd[0];
    dbg_req = d_req[1]; dbg_we = d_we[1]; dbg_addr = d_addr[1]; dbg_wdata = d_wd[1];
    dbg_lock = d_lock;
    @(negedge CLK);
    obs_cpu_gnt = cpu_gnt; obs_mem_en = mem_en; obs_mem_addr = mem_addr;
    obs_cpu_rvalid = cpu_rvalid; obs_cpu_err = cpu_err; obs_cpu_rdata = cpu_rdata;
    if (RESET_N) begin
      check_val("rst_ctrl", 64'({cpu_gnt, cpu_rvalid, cpu_err, dbg_gnt, dbg_rvalid,
                                 dbg_err, mem_en, mem_we}), 64'd0);
      check_val("rst_rdata", {cpu_rdata, dbg_rdata}, 64'd0);
      check_val("rst_mem", 64'({mem_addr, mem_wdata}), 64'd0);
      model_reset();
    end else begin
      model_cycle();
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic set_port(input int p, input logic rq, input logic we,
                          input logic [31:0] a, input logic [31:0] w);
    d_req[p] = rq; d_we[p] = we; d_addr[p] = a; d_wd[p] = w;
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 19);
    if (r < 14)       return 32'($urandom_range(0, 15)) * 32'd4;
    else if (r == 14) return 32'($urandom_range(0, 15)) * 32'd4 + 32'($urandom_range(1, 3));
    else if (r == 15) return 32'(DEPTH * 4) + 32'($urandom_range(0, 255)) * 32'd4;
    else if (r == 16) return 32'h8000_0000 | (32'($urandom_range(0, DEPTH - 1)) << 2);
    else              return 32'($urandom_range(0, DEPTH - 1)) * 32'd4;
  endfunction

  task automatic rand_drive();
    for (int p = 0; p < 2; p++) begin
      if (d_req[p] && !granted[p]) begin
        if ($urandom_range(0, 9) == 0) d_req[p] = 1'b0;
      end else begin
        set_port(p, $urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
      end
    end
    if ($urandom_range(0, 6) == 0) d_lock = ~d_lock;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) shadow[i] = seed_word(i);
    for (int p = 0; p < 2; p++) set_port(p, 1'b0, 1'b0, 32'd0, 32'd0);
    d_lock = 1'b0;
    model_reset();

    RESET_N = 1'b1; step(); step();
    RESET_N = 1'b0; step();

    // Reset while a read is in flight: its response is dropped
    set_port(0, 1'b1, 1'b0, 32'h10, 32'd0); step();
    check_val("mid_gnt", 64'(obs_cpu_gnt), 64'd1);
    set_port(0, 1'b0, 1'b0, 32'd0, 32'd0); RESET_N = 1'b1; step();
    RESET_N = 1'b0; step();
    check_val("mid_no_rvalid", 64'(obs_cpu_rvalid), 64'd0);

    // Contention from reset: CPU, DBG, CPU, DBG
    set_port(0, 1'b1, 1'b0, 32'h0, 32'd0); set_port(1, 1'b1, 1'b0, 32'h4, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check_val("cont_order", 64'(obs_cpu_gnt), 64'((i % 2) == 0));
    end
    set_port(0, 1'b0, 1'b0, 32'd0, 32'd0); set_port(1, 1'b0, 1'b0, 32'd0, 32'd0); step();

    // Lock: one CPU grant so DBG is favoured, then DBG locks for 4 cycles
    set_port(0, 1'b1, 1'b0, 32'h8, 32'd0); step();
    set_port(1, 1'b1, 1'b0, 32'hC, 32'd0); d_lock = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_val("lock_cpu_gnt", 64'(obs_cpu_gnt), 64'd0);
    end
    d_lock = 1'b0; step();
    check_val("unlock_cpu_win", 64'(obs_cpu_gnt), 64'd1);
    set_port(0, 1'b0, 1'b0, 32'd0, 32'd0); set_port(1, 1'b0, 1'b0, 32'd0, 32'd0); step();

    // Misaligned write, then out-of-range read
    set_port(0, 1'b1, 1'b1, 32'h1002, 32'h1234_5678); step();
    check_val("err_wr_gnt", 64'(obs_cpu_gnt), 64'd1);
    check_val("err_wr_mem_en", 64'(obs_mem_en), 64'd0);
    set_port(0, 1'b1, 1'b0, 32'h1000, 32'd0); step();
    check_val("err_wr_rvalid", 64'(obs_cpu_rvalid), 64'd1);
    check_val("err_wr_err", 64'(obs_cpu_err), 64'd1);
    set_port(0, 1'b0, 1'b0, 32'd0, 32'd0); step();
    check_val("err_rd_err", 64'(obs_cpu_err), 64'd1);
    check_val("err_rd_rdata", 64'(obs_cpu_rdata), 64'd0);

    // DBG write then CPU read of the same word
    set_port(1, 1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF); step();
    check_val("wr_mem_addr", 64'(obs_mem_addr), 64'd8);
    set_port(1, 1'b0, 1'b0, 32'd0, 32'd0); set_port(0, 1'b1, 1'b0, 32'h20, 32'd0); step();
    check_val("rd_mem_addr", 64'(obs_mem_addr), 64'd8);
    set_port(0, 1'b0, 1'b0, 32'd0, 32'd0); step();
    check_val("rd_after_wr", 64'(obs_cpu_rdata), 64'hDEAD_BEEF);

    // 16 back-to-back CPU reads
    tp_gnt = 0; tp_rv = 0;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) set_port(0, 1'b1, 1'b0, 32'h40 + 32'(i) * 32'd4, 32'd0);
      else set_port(0, 1'b0, 1'b0, 32'd0, 32'd0);
      step();
      tp_gnt += int'(obs_cpu_gnt);
      tp_rv  += int'(obs_cpu_rvalid);
    end
    check_val("tp_grants", 64'(tp_gnt), 64'd16);
    check_val("tp_rvalids", 64'(tp_rv), 64'd16);

    // Random traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      rand_drive();
      RESET_N = ((i % 500) == 250);
      step();
    end
    RESET_N = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
